branch_resolve_unit: RTL and testbench

- Execute-stage consumer of the signed comparator: resolves conditional branches, JAL and JALR, and checks the front-end prediction.
- Instantiates one comparator_signed for BLT/BGE and computes EQ and unsigned LT locally.
- One-entry registered output stage with valid/ready backpressure and flush.
- Drives the fetch redirect and a saturating misprediction counter.

---
 rtl/branch_resolve_unit.sv | 166 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/JAL/JALR resolution with prediction check, a one-entry
// registered output stage (valid/ready + flush) and a saturating mispredict count.
module comparator_signed #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  lt_o
);
    assign lt_o = ($signed(a_i) < $signed(b_i));
endmodule

module branch_resolve_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  is_branch_i,
    input  logic                  is_jal_i,
    input  logic                  is_jalr_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic                  pred_taken_i,
    input  logic [DATA_WIDTH-1:0] pred_target_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  taken_o,
    output logic                  redirect_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic [DATA_WIDTH-1:0] link_o,
    output logic                  illegal_o,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt_o
);
    localparam logic [DATA_WIDTH-1:0] PC_INC  = DATA_WIDTH'(4);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

    logic                  eq_s, lts_s, ltu_s;
    logic                  cond_taken_s, cond_illegal_s;
    logic                  taken_s, illegal_s, mispredict_s, capture_s;
    logic [DATA_WIDTH-1:0] br_target_s, jalr_sum_s, target_s, next_pc_s, link_s;

    logic                  valid_q, valid_d;
    logic                  taken_q, taken_d;
    logic                  misp_q, misp_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [DATA_WIDTH-1:0] link_q, link_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    comparator_signed #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
        .a_i  (rs1_i),
        .b_i  (rs2_i),
        .lt_o (lts_s)
    );

    assign eq_s        = (rs1_i == rs2_i);
    assign ltu_s       = (rs1_i < rs2_i);
    assign br_target_s = pc_i + imm_i;
    assign jalr_sum_s  = rs1_i + imm_i;
    assign link_s      = pc_i + PC_INC;

    // Conditional-branch condition decode
    always_comb begin
        cond_taken_s   = 1'b0;
        cond_illegal_s = 1'b0;
        case (funct3_i)
            3'b000:  cond_taken_s = eq_s;
            3'b001:  cond_taken_s = !eq_s;
            3'b100:  cond_taken_s = lts_s;
            3'b101:  cond_taken_s = !lts_s;
            3'b110:  cond_taken_s = ltu_s;
            3'b111:  cond_taken_s = !ltu_s;
            default: cond_illegal_s = 1'b1;
        endcase
    end

    // Op resolution: JALR beats JAL beats conditional branch
    always_comb begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        target_s  = br_target_s;
        if (is_jalr_i) begin
            taken_s  = 1'b1;
            target_s = {jalr_sum_s[DATA_WIDTH-1:1], 1'b0};
        end else if (is_jal_i) begin
            taken_s = 1'b1;
        end else if (is_branch_i) begin
            taken_s   = cond_taken_s;
            illegal_s = cond_illegal_s;
        end else begin
            taken_s = 1'b0;
        end
    end

    assign next_pc_s    = taken_s ? target_s : link_s;
    assign mispredict_s = (taken_s != pred_taken_i) || (taken_s && (target_s != pred_target_i));
    assign in_ready_o   = !valid_q || out_ready_i;
    assign capture_s    = in_valid_i && in_ready_o && !flush_i;

    // Output-stage next state; flush wins over capture and kills the entry
    always_comb begin
        valid_d       = valid_q;
        taken_d       = taken_q;
        misp_d        = misp_q;
        illegal_d     = illegal_q;
        redirect_pc_d = redirect_pc_q;
        link_d        = link_q;
        cnt_d         = cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (capture_s) begin
            valid_d       = 1'b1;
            taken_d       = taken_s;
            misp_d        = mispredict_s;
            illegal_d     = illegal_s;
            redirect_pc_d = next_pc_s;
            link_d        = link_s;
            if (mispredict_s && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output-stage registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q       <= 1'b0;
            taken_q       <= 1'b0;
            misp_q        <= 1'b0;
            illegal_q     <= 1'b0;
            redirect_pc_q <= {DATA_WIDTH{1'b0}};
            link_q        <= {DATA_WIDTH{1'b0}};
            cnt_q         <= {CNT_WIDTH{1'b0}};
        end else begin
            valid_q       <= valid_d;
            taken_q       <= taken_d;
            misp_q        <= misp_d;
            illegal_q     <= illegal_d;
            redirect_pc_q <= redirect_pc_d;
            link_q        <= link_d;
            cnt_q         <= cnt_d;
        end
    end

    assign out_valid_o      = valid_q;
    assign taken_o          = taken_q;
    assign redirect_o       = valid_q && misp_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign link_o           = link_q;
    assign illegal_o        = illegal_q;
    assign mispredict_cnt_o = cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed test-plan steps plus
// randomized traffic against a behavioural model of the resolve stage.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0, pred_taken = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] rs1 = 32'd0, rs2 = 32'd0, pc = 32'd0, imm = 32'd0, pred_target = 32'd0;
    logic        in_ready_o, out_valid_o, taken_o, redirect_o, illegal_o;
    logic [31:0] redirect_pc_o, link_o;
    logic [15:0] cnt_o;
    logic        in_ready2, out_valid2, taken2, redirect2, illegal2;
    logic [31:0] redirect_pc2, link2;
    logic [1:0]  cnt2_o;

    int errors = 0;
    int checks = 0;

    // expected state of the registered stage
    logic        m_valid = 1'b0, m_taken = 1'b0, m_misp = 1'b0, m_ill = 1'b0;
    logic [31:0] m_npc = 32'd0, m_link = 32'd0;
    int          m_cnt = 0, m_cnt2 = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .is_branch_i(is_branch), .is_jal_i(is_jal), .is_jalr_i(is_jalr), .funct3_i(f3),
        .rs1_i(rs1), .rs2_i(rs2), .pc_i(pc), .imm_i(imm), .pred_taken_i(pred_taken),
        .pred_target_i(pred_target), .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .taken_o(taken_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .link_o(link_o), .illegal_o(illegal_o), .mispredict_cnt_o(cnt_o)
    );

    branch_resolve_unit #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .is_branch_i(is_branch), .is_jal_i(is_jal), .is_jalr_i(is_jalr), .funct3_i(f3),
        .rs1_i(rs1), .rs2_i(rs2), .pc_i(pc), .imm_i(imm), .pred_taken_i(pred_taken),
        .pred_target_i(pred_target), .out_valid_o(out_valid2), .out_ready_i(out_ready),
        .taken_o(taken2), .redirect_o(redirect2), .redirect_pc_o(redirect_pc2),
        .link_o(link2), .illegal_o(illegal2), .mispredict_cnt_o(cnt2_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Resolve the instruction currently on the inputs from the ISA rules.
    task automatic model(output logic tk, output logic ill, output logic [31:0] npc, output logic misp);
        int     sa, sb;
        longint ua, ub;
        logic [31:0] tgt;
        sa = rs1; sb = rs2;
        ua = {32'd0, rs1}; ub = {32'd0, rs2};
        tk = 1'b0; ill = 1'b0;
        tgt = pc + imm;
        if (is_jalr) begin
            tk = 1'b1;
            tgt = ((rs1 + imm) / 32'd2) * 32'd2;
        end else if (is_jal) begin
            tk = 1'b1;
        end else if (is_branch) begin
            if (f3 == 3'd0)      tk = (ua == ub);
            else if (f3 == 3'd1) tk = (ua != ub);
            else if (f3 == 3'd4) tk = (sa < sb);
            else if (f3 == 3'd5) tk = (sa >= sb);
            else if (f3 == 3'd6) tk = (ua < ub);
            else if (f3 == 3'd7) tk = (ua >= ub);
            else ill = 1'b1;
        end
        npc = tk ? tgt : pc + 32'd4;
        misp = (tk != pred_taken) || (tk && (tgt != pred_target));
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid_o, m_valid);
        chk("taken", taken_o, m_taken);
        chk("redirect", redirect_o, m_valid && m_misp);
        chk("redirect_pc", redirect_pc_o, m_npc);
        chk("link", link_o, m_link);
        chk("illegal", illegal_o, m_ill);
        chk("cnt16", cnt_o, 64'(m_cnt));
        chk("cnt2", cnt2_o, 64'(m_cnt2));
    endtask

    // One clock: check in_ready before the edge, advance the model, check after.
    task automatic tick();
        logic rdy, cap, tk, ill, misp;
        logic [31:0] npc;
        #2;
        rdy = !m_valid || out_ready;
        chk("in_ready", in_ready_o, rdy);
        cap = in_valid && rdy && !flush;
        model(tk, ill, npc, misp);
        @(posedge clk);
        #1;
        if (flush) begin
            m_valid = 1'b0;
        end else if (cap) begin
            m_valid = 1'b1; m_taken = tk; m_ill = ill; m_npc = npc; m_misp = misp;
            m_link = pc + 32'd4;
            if (misp) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        check_outputs();
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_taken = 1'b0; m_misp = 1'b0; m_ill = 1'b0;
        m_npc = 32'd0; m_link = 32'd0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic set_op(input logic br, input logic jal, input logic jalr, input logic [2:0] fn,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                          input logic [31:0] im, input logic pt, input logic [31:0] ptg);
        is_branch = br; is_jal = jal; is_jalr = jalr; f3 = fn;
        rs1 = a; rs2 = b; pc = p; imm = im; pred_taken = pt; pred_target = ptg;
    endtask

    initial begin
        logic tk, ill, misp;
        logic [31:0] npc;
        // reset state
        #2;
        check_outputs();
        #10 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // BLT negative vs positive, predicted not-taken
        in_valid = 1'b1;
        set_op(1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
        tick();
        chk("blt_taken", taken_o, 1'b1);
        chk("blt_redirect", redirect_o, 1'b1);
        chk("blt_pc", redirect_pc_o, 32'h120);
        chk("blt_cnt", cnt_o, 16'd1);

        // BLTU same operands
        set_op(1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
        tick();
        chk("bltu_taken", taken_o, 1'b0);
        chk("bltu_redirect", redirect_o, 1'b0);
        chk("bltu_pc", redirect_pc_o, 32'h104);
        chk("bltu_cnt", cnt_o, 16'd1);

        // JALR correctly predicted
        set_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h1001, 32'h0, 32'h200, 32'h4, 1'b1, 32'h1004);
        tick();
        chk("jalr_taken", taken_o, 1'b1);
        chk("jalr_redirect", redirect_o, 1'b0);
        chk("jalr_link", link_o, 32'h204);
        chk("jalr_pc", redirect_pc_o, 32'h1004);

        // backpressure: BEQ captured, then held for 3 cycles
        set_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'h55, 32'h300, 32'h40, 1'b1, 32'h340);
        tick();
        out_ready = 1'b0;
        set_op(1'b1, 1'b0, 1'b0, 3'b001, 32'h1, 32'h2, 32'h400, 32'h8, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_pc", redirect_pc_o, 32'h340);
        end
        out_ready = 1'b1;
        tick();
        chk("b2b_pc", redirect_pc_o, 32'h408);

        // flush over a held entry
        set_op(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h500, 32'h10, 1'b0, 32'h0);
        tick();
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        chk("flush_valid", out_valid_o, 1'b0);
        flush = 1'b0;
        in_valid = 1'b1;
        tick();

        // asynchronous reset mid-hold
        tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // five mispredicting captures saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            set_op(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h600 + 32'(i * 4), 32'h80, 1'b0, 32'h0);
            tick();
            chk("sat_cnt2", cnt2_o, (i < 3) ? 2'(i + 1) : 2'd3);
        end

        // illegal funct3
        set_op(1'b1, 1'b0, 1'b0, 3'b010, 32'h7, 32'h7, 32'h700, 32'h10, 1'b0, 32'h0);
        tick();
        chk("illegal", illegal_o, 1'b1);
        chk("illegal_taken", taken_o, 1'b0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 7);
            is_branch = (op < 5) || (op == 7);
            is_jal    = (op == 5) || (op == 7);
            is_jalr   = (op == 6) || ((op == 7) && ($urandom_range(0, 1) == 1));
            f3  = 3'($urandom_range(0, 7));
            rs1 = $urandom;
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            pc  = $urandom;
            imm = $urandom;
            pred_taken = 1'($urandom_range(0, 1));
            pred_target = $urandom;
            model(tk, ill, npc, misp);
            if ($urandom_range(0, 1) == 1) pred_target = npc;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 11) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
